// File: rtl/lsdbuf_pkg.sv
// Shared types and helpers for the LSD buffer fetcher.
//   lsdbuf_fetch_state_t : fetch sequencer states
//   HDR_MAGIC            : tag in the top 16 bits of an optional frame header beat
//   SEG_FIELD_W          : width of each packed coordinate field
//   pack_segment()       : packs one segment's endpoints into a 64-bit beat
package lsdbuf_pkg;

  localparam int          SEG_FIELD_W = 16;
  localparam logic [15:0] HDR_MAGIC   = 16'hA5A5;

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    READ,
    DRAIN,
    RELEASE
  } lsdbuf_fetch_state_t;

  // MSB to LSB: start_v, start_h, end_v, end_h (callers zero-extend)
  function automatic logic [4*SEG_FIELD_W-1:0] pack_segment(
    input logic [SEG_FIELD_W-1:0] start_v,
    input logic [SEG_FIELD_W-1:0] start_h,
    input logic [SEG_FIELD_W-1:0] end_v,
    input logic [SEG_FIELD_W-1:0] end_h
  );
    return {start_v, start_h, end_v, end_h};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO whose head entry sits in a dedicated output register, so
// pop_data comes straight from a flop. Total capacity is DEPTH entries
// (head register plus up to DEPTH-1 in the ring). Push and pop may happen
// in the same cycle even when full.
//   clk, n_rst       : clock, synchronous active-low reset (flushes)
//   push, push_data  : write strobe and data (ignored when full without pop)
//   pop              : consume the head entry (ignored when empty)
//   pop_data         : head entry, valid while empty=0
//   full, empty      : occupancy flags
//   count            : entries held, 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;
  logic             ring_empty;
  logic             to_head;
  logic             to_ring;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);
  assign ring_empty = (count <= CW'(1));
  // A push lands directly in the head register when nothing else is queued
  // ahead of it; otherwise it goes to the ring behind the head.
  assign to_head    = do_push & (empty | (do_pop & ring_empty));
  assign to_ring    = do_push & ~to_head;
  assign pop_data   = head_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      count <= count + CW'(do_push) - CW'(do_pop);
      if (to_head) begin
        head_q <= push_data;
      end else if (do_pop && !ring_empty) begin
        head_q <= mem[rptr];
        rptr   <= rptr + PW'(1);
      end
      if (to_ring) wptr <= wptr + PW'(1);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (to_ring) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/lsdbuf_fetcher.sv
// Reads every segment of a completed LSD buffer and streams it out as 64-bit
// AXI4-Stream beats. The buffer is write-protected for the whole walk; read
// issue is throttled by FIFO credits so back-pressure never drops a segment.
// Optional build macro LSDBUF_FETCHER_HEADER_EN prepends one header beat per
// frame: {A5A5, frame_cnt, 0000, n_lines}.
//   clk, n_rst                      : clock, synchronous active-low reset
//   in_lsdbuf_ready                 : level, buffer complete (rising edge starts a fetch)
//   in_lsdbuf_line_num              : number of valid segments
//   out_lsdbuf_raddr                : segment read address (holds between reads)
//   out_lsdbuf_write_protect        : freezes the buffer while high
//   in_lsdbuf_start_v/h, end_v/h    : read data, one cycle after the address
//   m_axis_tdata/tvalid/tready/tlast: AXI4-Stream master
//   out_busy                        : fetch in progress
//   out_frame_cnt                   : completed fetches, wraps at 16 bits
//   out_missed                      : sticky, a start edge arrived while busy
module lsdbuf_fetcher
  import lsdbuf_pkg::*;
#(
  parameter  int H_FRAME    = 1650,
  parameter  int V_FRAME    = 750,
  parameter  int RAM_SIZE   = 4096,
  parameter  int FIFO_DEPTH = 16,
  parameter  int LOCK_WAIT  = 2,
  localparam int HW         = $clog2(H_FRAME),
  localparam int VW         = $clog2(V_FRAME),
  localparam int AW         = $clog2(RAM_SIZE)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          in_lsdbuf_ready,
  input  logic [AW-1:0] in_lsdbuf_line_num,
  output logic [AW-1:0] out_lsdbuf_raddr,
  output logic          out_lsdbuf_write_protect,
  input  logic [VW-1:0] in_lsdbuf_start_v,
  input  logic [VW-1:0] in_lsdbuf_end_v,
  input  logic [HW-1:0] in_lsdbuf_start_h,
  input  logic [HW-1:0] in_lsdbuf_end_h,
  output logic [63:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          out_busy,
  output logic [15:0]   out_frame_cnt,
  output logic          out_missed
);

  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int LCW    = $clog2(LOCK_WAIT + 1);
  localparam int BEAT_W = 4*SEG_FIELD_W + 1;

  lsdbuf_fetch_state_t state, state_n;

  logic              ready_q;
  logic              start;
  logic [LCW-1:0]    lock_cnt;
  logic              lock_done;
  logic [AW-1:0]     n_lines;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     raddr_hold;
  logic              inflight;
  logic              last_pend;
  logic              is_last;
  logic              issue;
  logic              lock_exit;
  logic              credit;
  logic              hdr_push;
  logic              hdr_room;
  logic [BEAT_W-1:0] hdr_word;
  logic [BEAT_W-1:0] seg_word;
  logic              fifo_push;
  logic [BEAT_W-1:0] fifo_din;
  logic [BEAT_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign start     = in_lsdbuf_ready & ~ready_q;
  assign lock_done = (lock_cnt == LCW'(LOCK_WAIT - 1));
  assign is_last   = (rd_ptr == n_lines - AW'(1));
  // A read reserves a FIFO slot from issue until its data is pushed.
  assign credit    = ~fifo_full & ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

`ifdef LSDBUF_FETCHER_HEADER_EN
  // The header is pushed on the LOCK exit edge, so it needs a free slot then.
  assign hdr_room = ~fifo_full;
  assign hdr_push = lock_exit;
  assign hdr_word = {(in_lsdbuf_line_num == '0), HDR_MAGIC, out_frame_cnt, 16'h0000,
                     SEG_FIELD_W'(in_lsdbuf_line_num)};
`else
  assign hdr_room = 1'b1;
  assign hdr_push = 1'b0;
  assign hdr_word = '0;
`endif

  assign seg_word  = {last_pend, pack_segment(SEG_FIELD_W'(in_lsdbuf_start_v),
                                              SEG_FIELD_W'(in_lsdbuf_start_h),
                                              SEG_FIELD_W'(in_lsdbuf_end_v),
                                              SEG_FIELD_W'(in_lsdbuf_end_h))};
  // Header and returning read data never coincide: nothing is in flight in LOCK.
  assign fifo_push = hdr_push | inflight;
  assign fifo_din  = hdr_push ? hdr_word : seg_word;

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    lock_exit = 1'b0;
    unique case (state)
      IDLE:    if (start) state_n = LOCK;
      LOCK: begin
        if (lock_done && hdr_room) begin
          lock_exit = 1'b1;
          state_n   = READ;
        end
      end
      READ: begin
        if (n_lines == '0) begin
          state_n = DRAIN;
        end else if (credit) begin
          issue = 1'b1;
          if (is_last) state_n = DRAIN;
        end
      end
      DRAIN:   if (!inflight) state_n = RELEASE;
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ready_q       <= 1'b0;
      lock_cnt      <= '0;
      n_lines       <= '0;
      rd_ptr        <= '0;
      raddr_hold    <= '0;
      inflight      <= 1'b0;
      last_pend     <= 1'b0;
      out_frame_cnt <= '0;
      out_missed    <= 1'b0;
    end else begin
      ready_q   <= in_lsdbuf_ready;
      inflight  <= issue;
      last_pend <= issue & is_last;
      if (start && state != IDLE) out_missed <= 1'b1;
      if (state == IDLE && start) begin
        lock_cnt   <= '0;
        rd_ptr     <= '0;
        raddr_hold <= '0;
      end
      if (state == LOCK && !lock_done) lock_cnt <= lock_cnt + LCW'(1);
      if (lock_exit) n_lines <= in_lsdbuf_line_num;
      if (issue) begin
        raddr_hold <= rd_ptr;
        rd_ptr     <= rd_ptr + AW'(1);
      end
      if (state == RELEASE) out_frame_cnt <= out_frame_cnt + 16'd1;
    end
  end

  // The address is live in the issue cycle so the data returns one cycle later.
  assign out_lsdbuf_raddr         = issue ? rd_ptr : raddr_hold;
  assign out_busy                 = (state != IDLE);
  assign out_lsdbuf_write_protect = (state != IDLE);

  sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (m_axis_tready),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_dout[63:0];
  assign m_axis_tlast  = fifo_dout[64];

endmodule
